// File: rtl/instr_decode_pipe_pkg.sv
// Shared encodings for the ID stage: opcodes, immediate formats, result source
// and ALU operation codes.
package instr_decode_pipe_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;
  typedef enum logic {RES_ALU = 1'b0, RES_MEM = 1'b1} res_src_e;

  // ALU ops are {class[1:0], funct7[5], funct3}; class 00 = arith, 01 = compare
  localparam logic [5:0] ALU_ADD     = 6'h00;
  localparam logic [1:0] ALU_CLS_AR  = 2'b00;
  localparam logic [1:0] ALU_CLS_BR  = 2'b01;
  localparam logic [5:0] ALU_PASS_B  = 6'h20;

endpackage

// File: rtl/decode_control_unit.sv
// Control decode: write enable, result source, branch flag, ALU op, operand-B
// select and immediate format from the opcode/funct fields.
module decode_control_unit
  import instr_decode_pipe_pkg::*;
#(
  parameter int ALU_OP_W = 6
) (
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  output logic                reg_we,
  output logic                res_src,
  output logic                branch,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_input_conf,
  output imm_sel_e            imm_sel
);
  logic [5:0] op6;
  assign alu_op = ALU_OP_W'(op6);

  always_comb begin
    reg_we         = 1'b0;
    res_src        = RES_ALU;
    branch         = 1'b0;
    op6            = ALU_ADD;
    alu_input_conf = 1'b0;
    imm_sel        = IMM_I;
    unique case (opcode)
      OPC_LOAD:   begin reg_we = 1'b1; res_src = RES_MEM; alu_input_conf = 1'b1; end
      // funct7[5] only selects SRA among the immediate shifts
      OPC_OPIMM:  begin reg_we = 1'b1; alu_input_conf = 1'b1;
                        op6 = {ALU_CLS_AR, (funct3 == 3'b101) & funct7b5, funct3}; end
      OPC_OP:     begin reg_we = 1'b1; op6 = {ALU_CLS_AR, funct7b5, funct3}; end
      OPC_LUI:    begin reg_we = 1'b1; alu_input_conf = 1'b1; imm_sel = IMM_U; op6 = ALU_PASS_B; end
      OPC_AUIPC:  begin reg_we = 1'b1; alu_input_conf = 1'b1; imm_sel = IMM_U; end
      OPC_STORE:  begin alu_input_conf = 1'b1; imm_sel = IMM_S; end
      OPC_BRANCH: begin branch = 1'b1; imm_sel = IMM_B; op6 = {ALU_CLS_BR, 1'b0, funct3}; end
      OPC_JAL:    begin reg_we = 1'b1; imm_sel = IMM_J; end
      OPC_JALR:   begin reg_we = 1'b1; alu_input_conf = 1'b1; end
      default: ;
    endcase
  end
endmodule

// File: rtl/extender.sv
// Immediate extraction and sign extension to XLEN for all RV32 formats.
module extender
  import instr_decode_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_sel_e        imm_sel,
  output logic [XLEN-1:0] imm
);
  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    unique case (imm_sel)
      IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm32 = {instr[31:12], 12'b0};
      IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));
endmodule

// File: rtl/id_hazard_unit.sv
// Load-use detection against the instruction held in ID/EX, plus fetch handshake.
module id_hazard_unit #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  if_valid,
  input  logic                  ex_valid,
  input  logic                  ex_res_src,
  input  logic                  ex_rd_we,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  ex_stall,
  input  logic                  flush,
  output logic                  hz,
  output logic                  id_ready
);
  // Conservative: rs2 is compared even for formats that do not read it
  assign hz = if_valid & ex_valid & ex_res_src & ex_rd_we & (ex_rd_addr != '0) &
              ((ex_rd_addr == rs1) | (ex_rd_addr == rs2));

  // A flush consumes the wrong-path instruction even while EX is stalled
  assign id_ready = flush | (~ex_stall & ~hz);
endmodule

// File: rtl/regfile.sv
// 2R1W register file, x0 reads zero; contents are deliberately not reset.
module regfile #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [XLEN-1:0]       rdata1,
  output logic [XLEN-1:0]       rdata2
);
  logic [XLEN-1:0] mem [2**REG_ADDR_W];

  always_ff @(posedge clk)
    if (we && waddr != '0) mem[waddr] <= wdata;

  assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];
endmodule

// File: rtl/instr_decode_pipe.sv
// ID stage with ID/EX register: decode, operand read with writeback bypass,
// immediate extension, load-use bubble insertion, stall hold and flush.
module instr_decode_pipe
  import instr_decode_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [31:0]           instr,
  input  logic [XLEN-1:0]       pc_in,
  input  logic [XLEN-1:0]       next_pc_in,
  input  logic                  wb_write_enable,
  input  logic [REG_ADDR_W-1:0] wb_write_addr,
  input  logic [XLEN-1:0]       wb_write_data,
  input  logic                  ex_stall,
  input  logic                  flush,
  output logic                  id_ready,
  output logic                  valid_out,
  output logic [XLEN-1:0]       pc_out,
  output logic [XLEN-1:0]       next_pc_out,
  output logic                  rd_write_enable,
  output logic [REG_ADDR_W-1:0] rd_write_addr,
  output logic                  res_src,
  output logic                  branch,
  output logic [ALU_OP_W-1:0]   alu_op,
  output logic                  alu_input_conf,
  output logic [XLEN-1:0]       imm,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic [REG_ADDR_W-1:0] rs1_addr,
  output logic [REG_ADDR_W-1:0] rs2_addr
);
  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       pc, npc;
    logic                  rd_we;
    logic [REG_ADDR_W-1:0] rd;
    logic                  res_src;
    logic                  branch;
    logic [ALU_OP_W-1:0]   alu_op;
    logic                  conf;
    logic [XLEN-1:0]       imm, rs1d, rs2d;
    logic [REG_ADDR_W-1:0] rs1a, rs2a;
  } idex_t;

  idex_t idex_q, idex_d;

  imm_sel_e              imm_sel;
  logic                  dec_we, dec_res, dec_br, dec_conf, hz;
  logic [ALU_OP_W-1:0]   dec_aop;
  logic [XLEN-1:0]       dec_imm, rf_rd1, rf_rd2, rs1_byp, rs2_byp;
  logic [REG_ADDR_W-1:0] rs1_a, rs2_a, rd_a;

  assign rd_a  = instr[7  +: REG_ADDR_W];
  assign rs1_a = instr[15 +: REG_ADDR_W];
  assign rs2_a = instr[20 +: REG_ADDR_W];

  decode_control_unit #(.ALU_OP_W(ALU_OP_W)) u_dec (
    .opcode(instr[6:0]), .funct3(instr[14:12]), .funct7b5(instr[30]),
    .reg_we(dec_we), .res_src(dec_res), .branch(dec_br), .alu_op(dec_aop),
    .alu_input_conf(dec_conf), .imm_sel(imm_sel)
  );

  extender #(.XLEN(XLEN)) u_ext (.instr(instr[31:7]), .imm_sel(imm_sel), .imm(dec_imm));

  regfile #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_rf (
    .clk(clk), .we(wb_write_enable), .waddr(wb_write_addr), .wdata(wb_write_data),
    .raddr1(rs1_a), .raddr2(rs2_a), .rdata1(rf_rd1), .rdata2(rf_rd2)
  );

  id_hazard_unit #(.REG_ADDR_W(REG_ADDR_W)) u_hz (
    .if_valid(if_valid), .ex_valid(idex_q.valid), .ex_res_src(idex_q.res_src),
    .ex_rd_we(idex_q.rd_we), .ex_rd_addr(idex_q.rd), .rs1(rs1_a), .rs2(rs2_a),
    .ex_stall(ex_stall), .flush(flush), .hz(hz), .id_ready(id_ready)
  );

  // The write lands on the same edge as capture, so forward it here
  assign rs1_byp = (wb_write_enable && wb_write_addr != '0 && wb_write_addr == rs1_a) ? wb_write_data : rf_rd1;
  assign rs2_byp = (wb_write_enable && wb_write_addr != '0 && wb_write_addr == rs2_a) ? wb_write_data : rf_rd2;

  always_comb begin
    idex_d = idex_q;
    if (flush || (!ex_stall && (hz || !if_valid))) begin
      idex_d = '0;
    end else if (!ex_stall) begin
      idex_d.valid   = 1'b1;
      idex_d.pc      = pc_in;
      idex_d.npc     = next_pc_in;
      idex_d.rd_we   = dec_we & (rd_a != '0);
      idex_d.rd      = rd_a;
      idex_d.res_src = dec_res;
      idex_d.branch  = dec_br;
      idex_d.alu_op  = dec_aop;
      idex_d.conf    = dec_conf;
      idex_d.imm     = dec_imm;
      idex_d.rs1d    = rs1_byp;
      idex_d.rs2d    = rs2_byp;
      idex_d.rs1a    = rs1_a;
      idex_d.rs2a    = rs2_a;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;

  assign valid_out       = idex_q.valid;
  assign pc_out          = idex_q.pc;
  assign next_pc_out     = idex_q.npc;
  assign rd_write_enable = idex_q.rd_we;
  assign rd_write_addr   = idex_q.rd;
  assign res_src         = idex_q.res_src;
  assign branch          = idex_q.branch;
  assign alu_op          = idex_q.alu_op;
  assign alu_input_conf  = idex_q.conf;
  assign imm             = idex_q.imm;
  assign rs1_data        = idex_q.rs1d;
  assign rs2_data        = idex_q.rs2d;
  assign rs1_addr        = idex_q.rs1a;
  assign rs2_addr        = idex_q.rs2a;
endmodule

// File: tb/tb_instr_decode_pipe.sv
// Scoreboard bench: the driver queues hand-computed expectations, a negedge
// monitor pops and compares them against the ID/EX outputs and id_ready.
module tb_instr_decode_pipe;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_valid, wb_write_enable, ex_stall, flush;
  logic [31:0] instr, pc_in, next_pc_in, wb_write_data;
  logic [4:0]  wb_write_addr;
  logic        id_ready, valid_out, rd_write_enable, res_src, branch, alu_input_conf;
  logic [31:0] pc_out, next_pc_out, imm, rs1_data, rs2_data;
  logic [4:0]  rd_write_addr, rs1_addr, rs2_addr;
  logic [5:0]  alu_op;

  instr_decode_pipe #(.XLEN(32), .REG_ADDR_W(5), .ALU_OP_W(6)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .instr(instr), .pc_in(pc_in),
    .next_pc_in(next_pc_in), .wb_write_enable(wb_write_enable),
    .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
    .ex_stall(ex_stall), .flush(flush), .id_ready(id_ready), .valid_out(valid_out),
    .pc_out(pc_out), .next_pc_out(next_pc_out), .rd_write_enable(rd_write_enable),
    .rd_write_addr(rd_write_addr), .res_src(res_src), .branch(branch),
    .alu_op(alu_op), .alu_input_conf(alu_input_conf), .imm(imm),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ADDI1 = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] LW2   = 32'h0000A103;  // lw x2,0(x1)
  localparam logic [31:0] ADD3  = 32'h001101B3;  // add x3,x2,x1
  localparam logic [31:0] ADDI4 = 32'h00700213;  // addi x4,x0,7
  localparam logic [31:0] BEQ   = 32'h00000463;  // beq x0,x0,8

  typedef struct {
    bit          rdy, full, cimm, crs2;
    bit          valid, we, res, br, conf;
    logic [4:0]  rd, r1a, r2a;
    logic [5:0]  aop;
    logic [31:0] pc, npc, imm, r1d, r2d;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   npass = 0, ntot = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic exp_t mkb(bit rdy);
    exp_t e;
    e = '{default: '0};
    e.rdy = rdy;
    return e;
  endfunction

  function automatic exp_t mkf(bit rdy, bit valid, logic [31:0] pc, logic [31:0] npc,
                               bit we, logic [4:0] rd, bit res, bit br, logic [5:0] aop,
                               bit conf, logic [31:0] imm, bit cimm, logic [4:0] r1a,
                               logic [4:0] r2a, logic [31:0] r1d, bit crs2, logic [31:0] r2d);
    exp_t e;
    e = '{default: '0};
    e.rdy = rdy; e.full = 1'b1; e.valid = valid; e.pc = pc; e.npc = npc; e.we = we;
    e.rd = rd; e.res = res; e.br = br; e.aop = aop; e.conf = conf; e.imm = imm;
    e.cimm = cimm; e.r1a = r1a; e.r2a = r2a; e.r1d = r1d; e.crs2 = crs2; e.r2d = r2d;
    return e;
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("id_ready", 32'(id_ready), 32'(me.rdy));
      chk("valid_out", 32'(valid_out), 32'(me.valid));
      chk("rd_write_enable", 32'(rd_write_enable), 32'(me.we));
      chk("branch", 32'(branch), 32'(me.br));
      if (me.full) begin
        chk("pc_out", pc_out, me.pc);
        chk("next_pc_out", next_pc_out, me.npc);
        chk("rd_write_addr", 32'(rd_write_addr), 32'(me.rd));
        chk("res_src", 32'(res_src), 32'(me.res));
        chk("alu_op", 32'(alu_op), 32'(me.aop));
        chk("alu_input_conf", 32'(alu_input_conf), 32'(me.conf));
        chk("rs1_addr", 32'(rs1_addr), 32'(me.r1a));
        chk("rs2_addr", 32'(rs2_addr), 32'(me.r2a));
        chk("rs1_data", rs1_data, me.r1d);
        if (me.cimm) chk("imm", imm, me.imm);
        if (me.crs2) chk("rs2_data", rs2_data, me.r2d);
      end
    end
  end

  task automatic step(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                      input bit wbe, input logic [4:0] wba, input logic [31:0] wbd,
                      input bit st, input bit fl, input exp_t e);
    if_valid = iv; instr = ins; pc_in = pc; next_pc_in = pc + 32'd4;
    wb_write_enable = wbe; wb_write_addr = wba; wb_write_data = wbd;
    ex_stall = st; flush = fl;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  exp_t zero_rdy1, zero_rdy0, add_fr;

  initial begin
    if_valid = 0; instr = '0; pc_in = '0; next_pc_in = '0;
    wb_write_enable = 0; wb_write_addr = '0; wb_write_data = '0;
    ex_stall = 0; flush = 0;
    zero_rdy1 = mkf(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    zero_rdy0 = zero_rdy1; zero_rdy0.rdy = 0;
    add_fr    = mkf(0, 1, 32'h10C, 32'h110, 1, 3, 0, 0, 6'h00, 0, 0, 0, 2, 1, 32'h22, 1, 32'hDEADBEEF);

    @(posedge clk); #1;
    q.push_back(zero_rdy1);
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;

    // preload x1/x2 through writeback
    step(0, 0, 0, 1, 1, 32'h11, 0, 0, mkb(1));
    step(0, 0, 0, 1, 2, 32'h22, 0, 0, mkb(1));
    step(1, ADDI1, 32'h100, 0, 0, 0, 0, 0, mkb(1));
    step(1, LW2,   32'h104, 0, 0, 0, 0, 0,
         mkf(1, 1, 32'h100, 32'h104, 1, 1, 0, 0, 6'h00, 1, 5, 1, 0, 5, 0, 0, 0));
    step(1, ADD3,  32'h108, 0, 0, 0, 0, 0,
         mkf(0, 1, 32'h104, 32'h108, 1, 2, 1, 0, 6'h00, 1, 0, 1, 1, 0, 32'h11, 1, 0));
    // re-presented add; writeback to x0 must not bypass
    step(1, ADD3,  32'h108, 1, 0, 32'hDEADBEEF, 0, 0, mkb(1));
    step(1, ADD3,  32'h10C, 1, 1, 32'hDEADBEEF, 0, 0,
         mkf(1, 1, 32'h108, 32'h10C, 1, 3, 0, 0, 6'h00, 0, 0, 0, 2, 1, 32'h22, 1, 32'h11));
    for (int i = 0; i < 3; i++)
      step(1, ADDI4, 32'h110, 0, 0, 0, 1, 0, add_fr);
    add_fr.rdy = 1;
    step(1, ADDI4, 32'h110, 0, 0, 0, 1, 1, add_fr);
    step(1, LW2,   32'h200, 0, 0, 0, 0, 0, mkb(1));
    // if_valid low with rs1 matching the load in ID/EX: no hazard
    step(0, ADD3,  32'h204, 0, 0, 0, 0, 0,
         mkf(1, 1, 32'h200, 32'h204, 1, 2, 1, 0, 6'h00, 1, 0, 1, 1, 0, 32'hDEADBEEF, 1, 0));
    step(1, BEQ,   32'h280, 0, 0, 0, 0, 0, mkb(1));
    step(1, ADDI4, 32'h300, 0, 0, 0, 0, 0,
         mkf(1, 1, 32'h280, 32'h284, 0, 8, 0, 1, 6'h10, 0, 8, 1, 0, 0, 0, 1, 0));
    step(1, ADDI4, 32'h300, 0, 0, 0, 1, 0,
         mkf(0, 1, 32'h300, 32'h304, 1, 4, 0, 0, 6'h00, 1, 7, 1, 0, 7, 0, 0, 0));

    // async reset while stalled: outputs clear before the next posedge
    q.push_back(zero_rdy0);
    #1 rst = 1'b1;
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 0, 0, 0, zero_rdy1);

    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      ntot++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
